// File: rtl/binary_decoder_pkg.sv
// Shared widths, types and helpers for the registered 3-to-8 one-hot decoder.
package binary_decoder_pkg;

    localparam int IN_W  = 3;
    localparam int OUT_W = 8;

    typedef logic [IN_W-1:0]  sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input onehot_t v);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < OUT_W; i++) begin
            ones += 32'(v[i]);
        end
        return (ones == 1);
    endfunction

endpackage : binary_decoder_pkg

// File: rtl/binary_decoder_core.sv
// Combinational 3-to-8 decode: one-hot of in_i when e_i is high, all-zero otherwise.
module binary_decoder_core
    import binary_decoder_pkg::*;
(
    input  logic [IN_W-1:0]  in_i,
    input  logic             e_i,
    output logic [OUT_W-1:0] out_o
);

    always_comb begin
        // NOTE: default assigned first so every path drives out_o and no latch is inferred.
        out_o = '0;
        // The enable gates the shift, so an unknown index never reaches the output while disabled.
        if (e_i) begin
            out_o = onehot_t'(1) << in_i;
        end
    end

endmodule : binary_decoder_core

// File: rtl/binary_decoder_3_to_8.sv
// Registered 3-to-8 one-hot decoder with enable and a registered 'active' flag.
// Define BINARY_DECODER_ONEHOT_CHK_EN to add the sticky one-hot checker and its err_o port.
module binary_decoder_3_to_8
    import binary_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_i,
    input  logic             e_i,
    output logic [OUT_W-1:0] out_o,
    output logic             active_o
`ifdef BINARY_DECODER_ONEHOT_CHK_EN
    ,
    output logic             err_o
`endif
);

    onehot_t out_d, out_q;
    logic    active_d, active_q;

    binary_decoder_core u_core (
        .in_i  (in_i),
        .e_i   (e_i),
        .out_o (out_d)
    );

    assign active_d = e_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            active_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_q    <= out_d;
            active_q <= active_d;
        end
    end

    assign out_o    = out_q;
    assign active_o = active_q;

`ifdef BINARY_DECODER_ONEHOT_CHK_EN
    logic err_d, err_q;

    // Flags a registered value that contradicts the registered enable; sticky until reset.
    always_comb begin
        err_d = err_q;
        if (active_q ? !is_onehot(out_q) : (out_q != '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule : binary_decoder_3_to_8

// File: tb/tb_binary_decoder_3_to_8.sv
// Self-checking bench for binary_decoder_3_to_8: directed plan steps plus randomized traffic.
// Honours BINARY_DECODER_ONEHOT_CHK_EN to exercise the optional checker.
module tb_binary_decoder_3_to_8;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_i;
    logic       e_i;
    logic [7:0] out_o;
    logic       active_o;
`ifdef BINARY_DECODER_ONEHOT_CHK_EN
    logic       err_o;
`endif

    int checks   = 0;
    int failures = 0;

    binary_decoder_3_to_8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_i     (in_i),
        .e_i      (e_i),
        .out_o    (out_o),
        .active_o (active_o)
`ifdef BINARY_DECODER_ONEHOT_CHK_EN
        ,
        .err_o    (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the selected line is worth 2**index; disabled means no line.
    function automatic logic [7:0] model_out(input logic e, input logic [2:0] idx);
        int unsigned weight;
        weight = 1;
        repeat (int'(idx)) weight = weight * 2;
        return e ? 8'(weight) : 8'h00;
    endfunction

    // Drive inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input string tag, input logic e, input logic [2:0] idx);
        e_i  = e;
        in_i = idx;
        @(posedge clk);
        #1;
        check({tag, ".out"}, 32'(out_o), 32'(model_out(e, idx)));
        check({tag, ".active"}, 32'(active_o), 32'(e));
    endtask

    initial begin
        // Reset asserted with an enabled, nonzero request pending.
        rst_n = 1'b0;
        e_i   = 1'b1;
        in_i  = 3'd5;
        #2;
        check("reset.out", 32'(out_o), 32'h00);
        check("reset.active", 32'(active_o), 32'h0);
`ifdef BINARY_DECODER_ONEHOT_CHK_EN
        check("reset.err", 32'(err_o), 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_held.out", 32'(out_o), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release.out", 32'(out_o), 32'h00);
        check("release.active", 32'(active_o), 32'h0);

        // Disabled: index ignored.
        step("dis5", 1'b0, 3'b101);
        step("dis4", 1'b0, 3'b100);

        // Full sweep, one index per cycle.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("sweep%0d", i), 1'b1, 3'(i));
        end
        e_i  = 1'b1;
        in_i = 3'd0;
        @(posedge clk);
        #1;
        check("sweep_first.out", 32'(out_o), 32'h01);
        e_i  = 1'b1;
        in_i = 3'd7;
        @(posedge clk);
        #1;
        check("sweep_last.out", 32'(out_o), 32'h80);

        // Enable toggle with the index held.
        step("tog_on", 1'b1, 3'd6);
        check("tog_on.lit", 32'(out_o), 32'h40);
        step("tog_off", 1'b0, 3'd6);

        // Asynchronous reset between edges while out = 80.
        step("pre_rst", 1'b1, 3'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out", 32'(out_o), 32'h00);
        check("midrst.active", 32'(active_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 3'd2);
        check("post_rst.lit", 32'(out_o), 32'h04);

        // Randomized traffic against the model, plus an at-most-one-hot property.
        for (int n = 0; n < 60; n++) begin
            step($sformatf("rand%0d", n), 1'($urandom_range(0, 3) != 0), 3'($urandom));
            check($sformatf("rand%0d.ones", n), 32'($countones(out_o) <= 1), 32'h1);
        end

`ifdef BINARY_DECODER_ONEHOT_CHK_EN
        check("chk_clean.err", 32'(err_o), 32'h0);
        step("chk_setup", 1'b1, 3'd1);
        force dut.out_q = 8'h03;
        @(posedge clk);
        #1;
        release dut.out_q;
        check("chk_trip.err", 32'(err_o), 32'h1);
        step("chk_after1", 1'b1, 3'd3);
        step("chk_after2", 1'b0, 3'd0);
        check("chk_sticky.err", 32'(err_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("chk_rst.err", 32'(err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("chk_post", 1'b1, 3'd4);
        check("chk_post.err", 32'(err_o), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_binary_decoder_3_to_8
